// File: rtl/golden_nonce_collector.sv
// Nonce issuer and result checker for a fixed-latency SHA256 pipe; golden nonces are
// queued in a small FIFO with a valid/ready host port.
module golden_nonce_collector #(
   parameter int unsigned LATENCY     = 135,
   parameter logic [31:0] MATCH_VALUE = 32'ha41f32e7,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] nonce_base,
   input  logic [31:0] nonce_last,
   output logic [31:0] nonce_out,
   output logic        nonce_valid,
   input  logic [31:0] hash_word,
   output logic        gn_valid,
   output logic [31:0] gn_nonce,
   input  logic        gn_ready,
   output logic        busy,
   output logic        done,
   output logic        overflow
);

   localparam int unsigned LW = $clog2(LATENCY + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] LAT_M1 = LW'(LATENCY - 1);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    state_q;
   logic [31:0]   nonce_q;
   logic          nvalid_q;
   logic [31:0]   last_q;
   logic [31:0]   chk_nonce_q;
   logic          chk_active_q;
   logic [LW-1:0] lat_cnt_q;
   logic          done_q;
   logic          overflow_q;

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   cnt_q;

   logic chk_hit;
   logic pop;
   logic full;
   logic push_ok;
   logic drop;

   // A start edge abandons whatever the old job would have checked at that edge.
   assign chk_hit = chk_active_q & (hash_word == MATCH_VALUE) & ~start;
   assign pop     = gn_valid & gn_ready;
   assign full    = (cnt_q == FULL_CNT);
   assign push_ok = chk_hit & (~full | pop);
   assign drop    = chk_hit & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         nonce_q      <= '0;
         nvalid_q     <= 1'b0;
         last_q       <= '0;
         chk_nonce_q  <= '0;
         chk_active_q <= 1'b0;
         lat_cnt_q    <= '0;
         done_q       <= 1'b0;
      end else if (start) begin
         state_q      <= S_RUN;
         nonce_q      <= nonce_base;
         nvalid_q     <= 1'b1;
         last_q       <= nonce_last;
         chk_nonce_q  <= nonce_base;
         chk_active_q <= 1'b0;
         lat_cnt_q    <= LW'(1);
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (nvalid_q) begin
            if (nonce_q == last_q) begin
               nvalid_q <= 1'b0;
               state_q  <= S_DRAIN;
            end else begin
               nonce_q <= nonce_q + 32'd1;
            end
         end
         // lat_cnt counts edges since start; checking begins LATENCY edges after start.
         if (lat_cnt_q != '0) begin
            if (lat_cnt_q == LAT_M1) begin
               chk_active_q <= 1'b1;
               lat_cnt_q    <= '0;
            end else begin
               lat_cnt_q <= lat_cnt_q + LW'(1);
            end
         end
         if (chk_active_q) begin
            if (chk_nonce_q == last_q) begin
               chk_active_q <= 1'b0;
               state_q      <= S_IDLE;
               done_q       <= 1'b1;
            end else begin
               chk_nonce_q <= chk_nonce_q + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (start) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= chk_nonce_q;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push_ok && !pop) begin
            cnt_q <= cnt_q + (AW + 1)'(1);
         end else if (pop && !push_ok) begin
            cnt_q <= cnt_q - (AW + 1)'(1);
         end
      end
   end

   assign nonce_out   = nonce_q;
   assign nonce_valid = nvalid_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign overflow    = overflow_q;
   assign gn_valid    = (cnt_q != '0);
   assign gn_nonce    = mem_q[rd_ptr_q];

endmodule
